// File: rtl/dma_request_agent.sv
// Single-channel DMA request agent: a shared FIFO, the DREQ/DACK handshake FSM and a strobe-edge byte mover.
// Optional terminal-count support is compiled in with `define DMA_AGENT_TC_EN.
module dma_request_agent #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned THRESHOLD = 1
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     enable,
    input  logic                     dir,
    input  logic [7:0]               localData,
    input  logic                     localPush,
    output logic                     localFull,
    output logic [7:0]               localRdData,
    input  logic                     localPop,
    output logic                     localEmpty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     DREQ,
    input  logic                     DACK,
    input  logic                     IOR_N,
    input  logic                     IOW_N,
    input  logic                     EOP_N,
    input  logic [7:0]               DB_IN,
    output logic [7:0]               DB_OUT,
    output logic                     DB_OE,
    output logic                     tcFlag,
    input  logic                     tcClear
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} state_t;

    state_t         state;
    state_t         nextState;
    logic           dirLat;
    logic           effDir;
    logic           iorPrev;
    logic           iowPrev;
    logic           strobe;
    logic           strobePrev;
    logic           xferDone;
    logic           reqCond;
    logic [7:0]     busLatch;
    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  wrPtr;
    logic [AW-1:0]  rdPtr;
    logic           pushReq;
    logic           popReq;
    logic           doPush;
    logic           doPop;
    logic [7:0]     pushData;

    // dir is live while IDLE and frozen in dirLat for the rest of the grant
    assign effDir     = (state == IDLE) ? dir : dirLat;
    assign strobe     = dirLat ? IOW_N : IOR_N;
    assign strobePrev = dirLat ? iowPrev : iorPrev;
    assign xferDone   = (state == XFER) && DACK && strobe && !strobePrev;

    assign localFull   = (count == CW'(DEPTH));
    assign localEmpty  = (count == '0);
    assign localRdData = mem[rdPtr];

    // Local port serves the side the bus does not: one push and one pop at most per cycle
    assign pushReq  = effDir ? xferDone : localPush;
    assign pushData = effDir ? busLatch : localData;
    assign popReq   = effDir ? localPop : xferDone;
    assign doPush   = pushReq && !localFull;
    assign doPop    = popReq && !localEmpty;

    assign reqCond = dir ? ((CW'(DEPTH) - count) >= CW'(THRESHOLD))
                         : (count >= CW'(THRESHOLD));

    always_ff @(posedge CLK) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            iorPrev  <= 1'b1;
            iowPrev  <= 1'b1;
            dirLat   <= 1'b0;
            busLatch <= '0;
        end else begin
            iorPrev <= IOR_N;
            iowPrev <= IOW_N;
            if (state == IDLE) begin
                dirLat <= dir;
            end
            if ((state == XFER) && DACK && !IOW_N) begin
                busLatch <= DB_IN;
            end
        end
    end

`ifdef DMA_AGENT_TC_EN
    logic eopSeen;
    logic tcReg;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            eopSeen <= 1'b0;
            tcReg   <= 1'b0;
        end else begin
            if (state == XFER) begin
                if (!EOP_N) begin
                    eopSeen <= 1'b1;
                end
            end else begin
                eopSeen <= 1'b0;
            end
            if (tcClear) begin
                tcReg <= 1'b0;
            end else if (xferDone && (eopSeen || !EOP_N)) begin
                tcReg <= 1'b1;
            end
        end
    end

    assign tcFlag = tcReg;
`else
    logic unusedTc;
    assign unusedTc = ^{EOP_N, tcClear};
    assign tcFlag   = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            DREQ  <= 1'b0;
        end else begin
            state <= nextState;
            DREQ  <= (nextState == REQ) || (nextState == XFER);
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (enable && !tcFlag && reqCond) begin
                    nextState = REQ;
                end
            end
            REQ: begin
                if (!enable) begin
                    nextState = IDLE;
                end else if (DACK) begin
                    nextState = XFER;
                end
            end
            XFER: begin
                if (xferDone) begin
                    nextState = GAP;
                end else if (!DACK) begin
                    nextState = REQ;
                end
            end
            GAP: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_comb begin
        DB_OE  = (state == XFER) && !dirLat && DACK && !IOR_N;
        DB_OUT = '0;
        if (DB_OE) begin
            DB_OUT = mem[rdPtr];
        end
    end

endmodule

// File: tb/tb_dma_request_agent.sv
// Self-checking bench for dma_request_agent: table-driven local FIFO vectors plus scripted bus handshakes.
// Expected bytes flow through a scoreboard queue filled when data is driven in.
module tb_dma_request_agent;

    localparam int unsigned DEPTH = 4;
`ifdef DMA_AGENT_TC_EN
    localparam bit TC_EN = 1'b1;
`else
    localparam bit TC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstN;
    logic       enable;
    logic       dir;
    logic [7:0] localData;
    logic       localPush;
    logic       localFull;
    logic [7:0] localRdData;
    logic       localPop;
    logic       localEmpty;
    logic [2:0] count;
    logic       DREQ;
    logic       DACK;
    logic       IOR_N;
    logic       IOW_N;
    logic       EOP_N;
    logic [7:0] DB_IN;
    logic [7:0] DB_OUT;
    logic       DB_OE;
    logic       tcFlag;
    logic       tcClear;

    dma_request_agent #(.DEPTH(DEPTH), .THRESHOLD(1)) dut (
        .CLK(clk), .RESET_N(rstN), .enable(enable), .dir(dir),
        .localData(localData), .localPush(localPush), .localFull(localFull),
        .localRdData(localRdData), .localPop(localPop), .localEmpty(localEmpty),
        .count(count), .DREQ(DREQ), .DACK(DACK), .IOR_N(IOR_N), .IOW_N(IOW_N),
        .EOP_N(EOP_N), .DB_IN(DB_IN), .DB_OUT(DB_OUT), .DB_OE(DB_OE),
        .tcFlag(tcFlag), .tcClear(tcClear)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       d;
        logic       push;
        logic       pop;
        logic [7:0] data;
        logic [2:0] expCount;
        logic       expFull;
        logic       expEmpty;
    } vec_t;

    vec_t       vecs[10];
    logic [7:0] sb[$];
    int         checks = 0;
    int         failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitDreq(input string name);
        int n = 0;
        while (!DREQ && n < 20) begin
            tick();
            n++;
        end
        check(name, DREQ, 1);
    endtask

    task automatic pushLocal(input logic [7:0] b);
        localData = b;
        localPush = 1'b1;
        sb.push_back(b);
        tick();
        localPush = 1'b0;
    endtask

    task automatic popLocal(input string name);
        logic [7:0] exp;
        localPop = 1'b1;
        #1;
        exp = (sb.size() > 0) ? sb.pop_front() : 8'hXX;
        check(name, localRdData, exp);
        tick();
        localPop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        logic [7:0] exp;
        int mCount;
        int seen;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 8'hA5, 3'd1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h3C, 3'd2, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 8'h5A, 3'd3, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 8'h77, 3'd4, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 8'h99, 3'd4, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 8'h00, 3'd1, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b1};
        vecs[9] = '{1'b1, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b1};

        rstN = 1'b0; enable = 1'b0; dir = 1'b0; localData = '0; localPush = 1'b0;
        localPop = 1'b0; DACK = 1'b0; IOR_N = 1'b1; IOW_N = 1'b1; EOP_N = 1'b1;
        DB_IN = '0; tcClear = 1'b0;
        #1;
        check("rst_dreq", DREQ, 0);
        check("rst_count", count, 0);
        check("rst_dbOe", DB_OE, 0);
        check("rst_empty", localEmpty, 1);
        check("rst_tc", tcFlag, 0);
        repeat (2) @(posedge clk);
        #3 rstN = 1'b1;
        tick();

        // Local FIFO vectors, requests disabled
        mCount = 0;
        for (int i = 0; i < 10; i++) begin
            dir = vecs[i].d; localPush = vecs[i].push; localPop = vecs[i].pop;
            localData = vecs[i].data;
            #1;
            if (vecs[i].pop && mCount > 0) begin
                exp = sb.pop_front();
                check($sformatf("vec%0d_rdData", i), localRdData, exp);
                mCount--;
            end
            if (vecs[i].push && mCount < DEPTH) begin
                sb.push_back(vecs[i].data);
                mCount++;
            end
            tick();
            localPush = 1'b0; localPop = 1'b0;
            check($sformatf("vec%0d_count", i), count, vecs[i].expCount);
            check($sformatf("vec%0d_full", i), localFull, vecs[i].expFull);
            check($sformatf("vec%0d_empty", i), localEmpty, vecs[i].expEmpty);
            check($sformatf("vec%0d_model", i), count, mCount);
        end

        // Device-to-memory single byte
        dir = 1'b0; enable = 1'b1;
        pushLocal(8'hA5);
        check("req031_noDreqYet", DREQ, 0);
        tick();
        check("req031_dreq", DREQ, 1);
        DACK = 1'b1;
        tick();
        IOR_N = 1'b0;
        #1;
        exp = sb.pop_front();
        check("req031_dbOut", DB_OUT, exp);
        check("req031_dbOe", DB_OE, 1);
        tick(); tick();
        check("req031_dbOutHold", DB_OUT, exp);
        IOR_N = 1'b1;
        #1;
        check("req031_dbOeOff", DB_OE, 0);
        check("req031_dbOutOff", DB_OUT, 0);
        tick();
        check("req031_count", count, 0);
        check("req031_gap1", DREQ, 0);
        DACK = 1'b0;
        tick();
        check("req031_gap2", DREQ, 0);

        // DACK withdrawn mid-byte
        pushLocal(8'h42);
        waitDreq("req035_dreq");
        DACK = 1'b1; tick();
        IOR_N = 1'b0; tick();
        DACK = 1'b0; tick();
        check("req035_backToReq", DREQ, 1);
        check("req035_noPop", count, 1);
        IOR_N = 1'b1; tick();
        check("req035_holdReq", DREQ, 1);
        DACK = 1'b1; tick();
        IOR_N = 1'b0;
        #1;
        exp = sb.pop_front();
        check("req035_dbOut", DB_OUT, exp);
        tick();
        IOR_N = 1'b1; tick();
        check("req035_count", count, 0);
        DACK = 1'b0;

        // Local push coinciding with bus pop
        enable = 1'b0; tick(); tick();
        pushLocal(8'h11);
        pushLocal(8'h22);
        enable = 1'b1;
        waitDreq("req023_dreq");
        DACK = 1'b1; tick();
        IOR_N = 1'b0;
        #1;
        exp = sb.pop_front();
        check("req023_dbOut", DB_OUT, exp);
        tick();
        IOR_N = 1'b1; localData = 8'h33; localPush = 1'b1; sb.push_back(8'h33);
        tick();
        localPush = 1'b0;
        check("req023_net", count, 2);
        DACK = 1'b0; enable = 1'b0;
        tick(); tick();
        dir = 1'b1;
        popLocal("req023_pop0");
        popLocal("req023_pop1");
        check("req023_empty", localEmpty, 1);

        // Memory-to-device fill
        dir = 1'b1; enable = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            waitDreq($sformatf("req032_dreq%0d", i));
            DACK = 1'b1; tick();
            IOW_N = 1'b0; DB_IN = 8'(i); tick();
            IOW_N = 1'b1; DB_IN = 8'hEE; tick();
            DACK = 1'b0;
            sb.push_back(8'(i));
        end
        check("req032_count", count, 4);
        check("req032_full", localFull, 1);
        seen = 0;
        repeat (5) begin
            tick();
            if (DREQ) seen = 1;
        end
        check("req032_noDreqFull", seen, 0);
        enable = 1'b0;
        for (int i = 0; i < 4; i++) popLocal($sformatf("req032_pop%0d", i));
        check("req032_empty", localEmpty, 1);

        // Terminal count
        dir = 1'b0; tick();
        for (int i = 0; i < 4; i++) pushLocal(8'hB0 + 8'(i));
        enable = 1'b1;
        waitDreq("tc_dreq");
        DACK = 1'b1; tick();
        IOR_N = 1'b0; EOP_N = 1'b0;
        #1;
        exp = sb.pop_front();
        check("tc_dbOut", DB_OUT, exp);
        tick();
        IOR_N = 1'b1; EOP_N = 1'b1; tick();
        DACK = 1'b0;
        check("tc_count", count, 3);
        check("tc_flag", tcFlag, TC_EN);
        seen = 0;
        repeat (4) begin
            tick();
            if (DREQ) seen = 1;
        end
        check("tc_block", seen, !TC_EN);
        tcClear = 1'b1; tick(); tcClear = 1'b0;
        check("tc_cleared", tcFlag, 0);
        waitDreq("tc_reqAfterClear");
        enable = 1'b0; tick();
        check("req025_enableDrop", DREQ, 0);
        dir = 1'b1;
        for (int i = 0; i < 3; i++) popLocal($sformatf("tc_pop%0d", i));

        // Asynchronous reset in the middle of a byte
        dir = 1'b0; tick();
        pushLocal(8'hC7);
        enable = 1'b1;
        waitDreq("req033_dreq");
        DACK = 1'b1; tick();
        IOR_N = 1'b0;
        #1;
        check("req033_dbOeBefore", DB_OE, 1);
        #2 rstN = 1'b0;
        #1;
        check("req033_dreq", DREQ, 0);
        check("req033_dbOe", DB_OE, 0);
        check("req033_dbOut", DB_OUT, 0);
        check("req033_count", count, 0);
        sb.delete();
        IOR_N = 1'b1; DACK = 1'b0; enable = 1'b0;
        #2 rstN = 1'b1;
        tick();
        check("req033_idleAfter", DREQ, 0);
        check("req033_emptyAfter", localEmpty, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_request_agent.md
DMA_REQUEST_AGENT -- requirements
Module: dma_request_agent

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set FIFO entries (power of two, >=2).
REQ-002 Parameter THRESHOLD, default 1, SHALL set the occupancy (dir=0) or free space (dir=1) needed to raise DREQ (1..DEPTH).
REQ-003 CLK  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 RESET_N  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 enable  in  1  SHALL gate new requests.
REQ-006 dir  in  1  SHALL select 0 = device-to-memory (agent sources bytes on IOR_N), 1 = memory-to-device (agent sinks bytes on IOW_N); it is sampled only in IDLE.
REQ-007 localData  in  8, localPush  in  1, localFull  out  1  SHALL be the local write port (used when dir=0).
REQ-008 localRdData  out  8, localPop  in  1, localEmpty  out  1  SHALL be the local read port (used when dir=1).
REQ-009 count  out  $clog2(DEPTH)+1  SHALL report FIFO occupancy.
REQ-010 DREQ  out  1  SHALL be this channel's request to the controller.
REQ-011 DACK  in  1, IOR_N  in  1, IOW_N  in  1, EOP_N  in  1  SHALL be the controller handshake inputs (DACK active-high; strobes and EOP_N active-low), synchronous to CLK.
REQ-012 DB_IN  in  8, DB_OUT  out  8, DB_OE  out  1  SHALL form the data bus.
REQ-013 tcFlag  out  1, tcClear  in  1  SHALL report and clear terminal count.

Function
REQ-014 A single DEPTH-entry FIFO SHALL serve both directions; push to full or pop from empty SHALL be ignored, with no change to count.
REQ-015 The FSM SHALL have states IDLE, REQ, XFER, GAP.
REQ-016 IDLE->REQ SHALL occur when enable=1, tcFlag=0 and (dir=0 and count>=THRESHOLD, or dir=1 and DEPTH-count>=THRESHOLD).
REQ-017 DREQ SHALL be registered and equal 1 exactly in REQ and XFER.
REQ-018 REQ->XFER SHALL occur on the first cycle DACK is sampled 1; DREQ SHALL be held with no timeout until then.
REQ-019 In XFER, dir=0: DB_OE=1 and DB_OUT=FIFO head combinationally while DACK=1 and IOR_N=0; otherwise DB_OE=0 and DB_OUT=0.
REQ-020 A byte transfer SHALL complete on the cycle the active strobe is sampled 1 after having been sampled 0 (registered previous value); dir=0 pops the head, dir=1 pushes the DB_IN value latched while the strobe was low.
REQ-021 On transfer completion XFER->GAP; GAP SHALL last exactly one cycle and then go to IDLE (DREQ low for at least 2 cycles between grants).
REQ-022 DACK dropping in XFER before completion SHALL return to REQ without a transfer.
REQ-023 A simultaneous local push/pop and bus transfer in the same cycle SHALL both take effect; count changes by the net amount.
REQ-024 dir=1 with FIFO full at completion SHALL drop the byte; this is unreachable when THRESHOLD>=1.
REQ-025 Deasserting enable in REQ SHALL return to IDLE next cycle; in XFER it SHALL not abort the byte.
REQ-026 Pointers SHALL wrap modulo DEPTH; localFull = (count==DEPTH), localEmpty = (count==0).

Reset
REQ-027 RESET_N low SHALL immediately force IDLE, DREQ=0, DB_OE=0, DB_OUT=0, count=0, pointers=0, tcFlag=0, strobe history=1, including mid-XFER.
REQ-028 FIFO storage contents SHALL not require reset.

Configuration
REQ-029 With DMA_AGENT_TC_EN defined, EOP_N sampled 0 in XFER SHALL set tcFlag at transfer completion; tcFlag SHALL block IDLE->REQ until tcClear=1 clears it (tcClear wins over a simultaneous set).
REQ-030 Without DMA_AGENT_TC_EN, EOP_N and tcClear SHALL be ignored and tcFlag tied to 0.

Verification
REQ-031 dir=0, THRESHOLD=1, push 0xA5 -> DREQ=1 next cycle; DACK=1, IOR_N low 2 cycles -> DB_OUT=0xA5, DB_OE=1; IOR_N high -> count=0, DREQ=0 for 2 cycles.
REQ-032 dir=1, DEPTH=4, empty FIFO -> DREQ=1; 4 IOW_N pulses with DB_IN 0x01..0x04 -> count=4, DREQ stays 0, local pops return 0x01..0x04 in order.
REQ-033 RESET_N low while IOR_N=0 in XFER -> DREQ=0, DB_OE=0, count=0 with no clock edge.
REQ-034 DMA_AGENT_TC_EN defined, EOP_N=0 during a byte -> tcFlag=1, no DREQ with 3 bytes queued until tcClear=1, then DREQ=1.
REQ-035 DACK dropped after IOR_N low but before it rises -> no pop, FSM back in REQ, DREQ stays 1.
